// File: rtl/cpu_bridge_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bridge_pkg
// Shared definitions for the CPU <-> external bus bridge:
//   - CPU_R_* reply codes the bridge places on the external data bus
//   - core state codes that the bridge decodes from the core FSM
//   - bridge FSM state enumeration
// Reply codes are declared at MSG_W bits. Users resize them to their own
// data width.
// ---------------------------------------------------------------------------
package cpu_bridge_pkg;

    localparam int unsigned MSG_W        = 32;
    localparam int unsigned CORE_STATE_W = 8;

    // Replies to dispatcher polls
    localparam logic [MSG_W-1:0] CPU_R_VOID  = 32'h0000_00A0;
    localparam logic [MSG_W-1:0] CPU_R_START = 32'h0000_00A1;
    localparam logic [MSG_W-1:0] CPU_R_END   = 32'h0000_00A2;

    // Core FSM state codes the bridge cares about
    localparam logic [CORE_STATE_W-1:0] START_BEGIN    = 8'h01;
    localparam logic [CORE_STATE_W-1:0] READ_COND      = 8'h10;
    localparam logic [CORE_STATE_W-1:0] READ_DATA      = 8'h11;
    localparam logic [CORE_STATE_W-1:0] START_READ_CMD = 8'h12;
    localparam logic [CORE_STATE_W-1:0] FINISH_END     = 8'h7F;

    // Bridge FSM
    typedef enum logic [2:0] {
        ENUM   = 3'd0,
        PASS   = 3'd1,
        IDLE   = 3'd2,
        START  = 3'd3,
        RUN    = 3'd4,
        FINISH = 3'd5
    } bridge_state_e;

endpackage

// File: rtl/ext_bridge_ctrl_if.sv
// ---------------------------------------------------------------------------
// ext_bridge_ctrl_if
// The external multi-CPU bus as seen by one bridge.
// It covers enumeration chain, data, address, arbitration, dispatcher poll
// handshake and CPU index tagging.
//   slave  : bridge side (drives *_o / *_e / *_oe / ext_dispatcher_q)
//   master : bus / dispatcher side
// ---------------------------------------------------------------------------
interface ext_bridge_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 8
);
    logic              ext_rst_i;
    logic              ext_rst_e;
    logic [DATA_W-1:0] ext_data_i;
    logic [DATA_W-1:0] ext_data_o;
    logic              ext_data_oe;
    logic [ADDR_W-1:0] ext_addr_i;
    logic              ext_bus_busy_i;
    logic              ext_bus_busy_o;
    logic              ext_next_cpu_q;
    logic              ext_next_cpu_e;
    logic [IDX_W-1:0]  ext_cpu_index_i;
    logic [IDX_W-1:0]  ext_cpu_index_o;
    logic              ext_cpu_index_oe;
    logic              ext_dispatcher_q;

    modport slave (
        input  ext_rst_i, ext_data_i, ext_addr_i, ext_bus_busy_i,
               ext_next_cpu_q, ext_cpu_index_i,
        output ext_rst_e, ext_data_o, ext_data_oe, ext_bus_busy_o,
               ext_next_cpu_e, ext_cpu_index_o, ext_cpu_index_oe,
               ext_dispatcher_q
    );

    modport master (
        output ext_rst_i, ext_data_i, ext_addr_i, ext_bus_busy_i,
               ext_next_cpu_q, ext_cpu_index_i,
        input  ext_rst_e, ext_data_o, ext_data_oe, ext_bus_busy_o,
               ext_next_cpu_e, ext_cpu_index_o, ext_cpu_index_oe,
               ext_dispatcher_q
    );
endinterface

// File: rtl/bridge_poll_wdog.sv
// ---------------------------------------------------------------------------
// bridge_poll_wdog
// This is a saturating watchdog that counts cycles spent in RUN without a
// matching dispatcher poll.
//   clk, rst_n : clock, async active-low reset
//   run_en     : bridge is in RUN (count enable)
//   poll_clr   : matching poll seen; clears the counter and timeout
//   timeout    : registered flag, set when the count reaches WDOG_LIMIT
// Leaving RUN clears the counter but keeps timeout.
// ---------------------------------------------------------------------------
module bridge_poll_wdog #(
    parameter int WDOG_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_en,
    input  logic poll_clr,
    output logic timeout
);
    localparam int CNT_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WDOG_LIMIT);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             timeout_r;
    logic             timeout_s;

    // Next counter / flag values: clear has priority, then idle, then count
    always_comb begin
        cnt_s     = cnt_r;
        timeout_s = timeout_r;
        if (poll_clr) begin
            cnt_s     = {CNT_W{1'b0}};
            timeout_s = 1'b0;
        end else if (!run_en) begin
            cnt_s     = {CNT_W{1'b0}};
        end else if (cnt_r < LIMIT_C) begin
            cnt_s     = cnt_r + CNT_W'(1);
            timeout_s = ((cnt_r + CNT_W'(1)) == LIMIT_C);
        end else begin
            cnt_s     = LIMIT_C;
            timeout_s = 1'b1;
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            cnt_r     <= cnt_s;
            timeout_r <= timeout_s;
        end
    end

    assign timeout = timeout_r;

endmodule

// File: rtl/ext_bridge_ctrl.sv
// ---------------------------------------------------------------------------
// ext_bridge_ctrl
// This is the bridge between one CPU core and the shared external bus.
// It performs these functions:
//   - takes its CPU index from the reset enumeration chain and passes
//     index+1 downstream
//   - answers dispatcher polls with CPU_R_START / CPU_R_VOID / CPU_R_END
//   - hands the base address to the core and tags core reads with the index
//   - flags index overflow and poll watchdog timeout
// Ports:
//   clk, ext_rst_b          : clock, async active-low reset
//   bus (slave modport)     : external bus signals
//   core_state, core_read_q : core status inputs
//   core_rst, core_next_state, core_base_addr, core_start_dn : core control
//   cpu_index, enum_err, timeout : status
// Every output is registered. Each output responds one cycle after the
// input that causes it.
// ---------------------------------------------------------------------------
module ext_bridge_ctrl
    import cpu_bridge_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 8,
    parameter int STATE_W    = 8,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic               clk,
    input  logic               ext_rst_b,
    ext_bridge_ctrl_if.slave   bus,
    input  logic [STATE_W-1:0] core_state,
    input  logic               core_read_q,
    output logic               core_rst,
    output logic               core_next_state,
    output logic [ADDR_W-1:0]  core_base_addr,
    output logic               core_start_dn,
    output logic [IDX_W-1:0]   cpu_index,
    output logic               enum_err,
    output logic               timeout
);
    bridge_state_e     state_r, state_s;
    logic [IDX_W-1:0]  cpu_index_r, cpu_index_s;
    logic              enum_err_r, enum_err_s;
    logic [ADDR_W-1:0] base_addr_r, base_addr_s;

    logic              rst_e_r, rst_e_s;
    logic [DATA_W-1:0] data_o_r, data_o_s;
    logic              data_oe_r, data_oe_s;
    logic              busy_o_r, busy_o_s;
    logic              next_cpu_e_r, next_cpu_e_s;
    logic [IDX_W-1:0]  idx_o_r, idx_o_s;
    logic              idx_oe_r, idx_oe_s;
    logic              disp_q_r, disp_q_s;
    logic              core_rst_r, core_rst_s;
    logic              core_next_r, core_next_s;
    logic              start_dn_r, start_dn_s;

    logic [IDX_W-1:0]  idx_in_s;
    logic [IDX_W-1:0]  idx_inc_s;
    logic              match_s;
    logic              read_tag_s;
    logic              run_s;
    logic              unused_data_hi_s;

    assign idx_in_s  = bus.ext_data_i[IDX_W-1:0];
    assign idx_inc_s = idx_in_s + IDX_W'(1);
    // Only the low IDX_W bits of the enumeration word carry the index
    assign unused_data_hi_s = ^bus.ext_data_i;

    // A poll counts only once the index is final (IDLE and later).
    // It must carry our index, and the bus must be free.
    assign match_s = bus.ext_next_cpu_q && !bus.ext_bus_busy_i &&
                     (bus.ext_cpu_index_i == cpu_index_r) &&
                     (state_r != ENUM) && (state_r != PASS);

    assign read_tag_s = core_read_q &&
                        ((core_state == STATE_W'(READ_COND)) ||
                         (core_state == STATE_W'(READ_DATA)) ||
                         (core_state == STATE_W'(START_READ_CMD)));

    assign run_s = (state_r == RUN);

    // Next-state and next-output decode
    always_comb begin
        state_s      = state_r;
        cpu_index_s  = cpu_index_r;
        enum_err_s   = enum_err_r;
        base_addr_s  = base_addr_r;
        rst_e_s      = 1'b0;
        data_o_s     = {DATA_W{1'b0}};
        data_oe_s    = 1'b0;
        next_cpu_e_s = 1'b0;
        idx_o_s      = {IDX_W{1'b0}};
        idx_oe_s     = 1'b0;
        core_next_s  = 1'b0;
        start_dn_s   = 1'b0;

        // Any matching poll is acknowledged. The reply is VOID unless the
        // state below chooses a different one.
        if (match_s) begin
            next_cpu_e_s = 1'b1;
            data_oe_s    = 1'b1;
            data_o_s     = DATA_W'(CPU_R_VOID);
        end else begin
            next_cpu_e_s = 1'b0;
        end

        case (state_r)
            ENUM: begin
                if (bus.ext_rst_i) begin
                    if (&idx_in_s) begin
                        // All-ones is reserved. Flag it and keep waiting.
                        enum_err_s = 1'b1;
                    end else begin
                        cpu_index_s = idx_in_s;
                        rst_e_s     = 1'b1;
                        state_s     = PASS;
                        if (!bus.ext_bus_busy_i) begin
                            data_o_s  = DATA_W'(idx_inc_s);
                            data_oe_s = 1'b1;
                        end else begin
                            data_oe_s = 1'b0;
                        end
                    end
                end else begin
                    state_s = ENUM;
                end
            end
            PASS: begin
                state_s = IDLE;
            end
            IDLE: begin
                if (match_s) begin
                    data_o_s    = DATA_W'(CPU_R_START);
                    base_addr_s = bus.ext_addr_i;
                    core_next_s = 1'b1;
                    state_s     = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                start_dn_s = 1'b1;
                state_s    = RUN;
            end
            RUN: begin
                if (match_s && (core_state == STATE_W'(FINISH_END))) begin
                    data_o_s = DATA_W'(CPU_R_END);
                    state_s  = FINISH;
                end else begin
                    state_s = RUN;
                end
                if (read_tag_s && !bus.ext_bus_busy_i) begin
                    idx_o_s  = cpu_index_r;
                    idx_oe_s = 1'b1;
                end else begin
                    idx_oe_s = 1'b0;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = ENUM;
            end
        endcase

        // Level outputs follow the state being entered
        busy_o_s   = data_oe_s | idx_oe_s;
        core_rst_s = (state_s == ENUM) || (state_s == FINISH);
        disp_q_s   = !((state_s == START) || (state_s == RUN));
    end

    // State, status and output registers
    always_ff @(posedge clk or negedge ext_rst_b) begin
        if (!ext_rst_b) begin
            state_r      <= ENUM;
            cpu_index_r  <= {IDX_W{1'b1}};
            enum_err_r   <= 1'b0;
            base_addr_r  <= {ADDR_W{1'b0}};
            rst_e_r      <= 1'b0;
            data_o_r     <= {DATA_W{1'b0}};
            data_oe_r    <= 1'b0;
            busy_o_r     <= 1'b0;
            next_cpu_e_r <= 1'b0;
            idx_o_r      <= {IDX_W{1'b0}};
            idx_oe_r     <= 1'b0;
            disp_q_r     <= 1'b1;
            core_rst_r   <= 1'b1;
            core_next_r  <= 1'b0;
            start_dn_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            cpu_index_r  <= cpu_index_s;
            enum_err_r   <= enum_err_s;
            base_addr_r  <= base_addr_s;
            rst_e_r      <= rst_e_s;
            data_o_r     <= data_o_s;
            data_oe_r    <= data_oe_s;
            busy_o_r     <= busy_o_s;
            next_cpu_e_r <= next_cpu_e_s;
            idx_o_r      <= idx_o_s;
            idx_oe_r     <= idx_oe_s;
            disp_q_r     <= disp_q_s;
            core_rst_r   <= core_rst_s;
            core_next_r  <= core_next_s;
            start_dn_r   <= start_dn_s;
        end
    end

    bridge_poll_wdog #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (ext_rst_b),
        .run_en   (run_s),
        .poll_clr (match_s),
        .timeout  (timeout)
    );

    assign bus.ext_rst_e        = rst_e_r;
    assign bus.ext_data_o       = data_o_r;
    assign bus.ext_data_oe      = data_oe_r;
    assign bus.ext_bus_busy_o   = busy_o_r;
    assign bus.ext_next_cpu_e   = next_cpu_e_r;
    assign bus.ext_cpu_index_o  = idx_o_r;
    assign bus.ext_cpu_index_oe = idx_oe_r;
    assign bus.ext_dispatcher_q = disp_q_r;
    assign core_rst             = core_rst_r;
    assign core_next_state      = core_next_r;
    assign core_base_addr       = base_addr_r;
    assign core_start_dn        = start_dn_r;
    assign cpu_index            = cpu_index_r;
    assign enum_err             = enum_err_r;

endmodule

// File: tb/tb_ext_bridge_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ext_bridge_ctrl
// This is a directed bench for ext_bridge_ctrl with DATA_W=32, IDX_W=8 and
// WDOG_LIMIT=8.
// Inputs change 1 time unit after a rising edge. Registered outputs are
// checked at that same point, so they show the response to the previous edge.
// Reply codes: VOID=0xA0, START=0xA1, END=0xA2.
// Core codes: READ_DATA=0x11, FINISH_END=0x7F.
// ---------------------------------------------------------------------------
module tb_ext_bridge_ctrl;

    logic        clk;
    logic        ext_rst_b;
    logic [7:0]  core_state;
    logic        core_read_q;
    logic        core_rst;
    logic        core_next_state;
    logic [31:0] core_base_addr;
    logic        core_start_dn;
    logic [7:0]  cpu_index;
    logic        enum_err;
    logic        timeout;

    int vectors;
    int miscompares;

    ext_bridge_ctrl_if #(.DATA_W(32), .ADDR_W(32), .IDX_W(8)) bus ();

    ext_bridge_ctrl #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .IDX_W      (8),
        .STATE_W    (8),
        .WDOG_LIMIT (8)
    ) dut (
        .clk             (clk),
        .ext_rst_b       (ext_rst_b),
        .bus             (bus),
        .core_state      (core_state),
        .core_read_q     (core_read_q),
        .core_rst        (core_rst),
        .core_next_state (core_next_state),
        .core_base_addr  (core_base_addr),
        .core_start_dn   (core_start_dn),
        .cpu_index       (cpu_index),
        .enum_err        (enum_err),
        .timeout         (timeout)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poll(input logic q, input logic [7:0] idx, input logic [31:0] addr);
        bus.ext_next_cpu_q  = q;
        bus.ext_cpu_index_i = idx;
        bus.ext_addr_i      = addr;
    endtask

    // Directed sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        ext_rst_b   = 1'b0;
        core_state  = 8'h00;
        core_read_q = 1'b0;
        bus.ext_rst_i      = 1'b0;
        bus.ext_data_i     = 32'h0;
        bus.ext_bus_busy_i = 1'b0;
        poll(1'b0, 8'h00, 32'h0);

        // Reset state
        tick(); tick();
        chk("rst_core_rst",  core_rst, 1);
        chk("rst_disp_q",    bus.ext_dispatcher_q, 1);
        chk("rst_cpu_index", cpu_index, 8'hFF);
        chk("rst_data_oe",   bus.ext_data_oe, 0);
        chk("rst_rst_e",     bus.ext_rst_e, 0);
        chk("rst_enum_err",  enum_err, 0);
        chk("rst_timeout",   timeout, 0);
        chk("rst_base",      core_base_addr, 32'h0);
        ext_rst_b = 1'b1;

        // Poll in ENUM is ignored, even though it carries the reset index
        poll(1'b1, 8'hFF, 32'h0);
        tick();
        chk("enum_poll_ack", bus.ext_next_cpu_e, 0);
        poll(1'b0, 8'h00, 32'h0);

        // All-ones index is an overflow
        bus.ext_rst_i  = 1'b1;
        bus.ext_data_i = 32'h0000_00FF;
        tick();
        chk("ovf_enum_err", enum_err, 1);
        chk("ovf_rst_e",    bus.ext_rst_e, 0);
        chk("ovf_core_rst", core_rst, 1);

        // Valid enumeration with index 4
        bus.ext_data_i = 32'h0000_0004;
        tick();
        chk("enum_index",  cpu_index, 8'h04);
        chk("pass_rst_e",  bus.ext_rst_e, 1);
        chk("pass_data",   bus.ext_data_o, 32'h5);
        chk("pass_oe",     bus.ext_data_oe, 1);
        chk("pass_busy_o", bus.ext_bus_busy_o, 1);
        chk("pass_core_rst", core_rst, 0);

        // Poll while in PASS is ignored
        bus.ext_rst_i  = 1'b0;
        bus.ext_data_i = 32'h0;
        poll(1'b1, 8'h04, 32'h0);
        tick();
        chk("pass_poll_ack", bus.ext_next_cpu_e, 0);
        chk("idle_rst_e",    bus.ext_rst_e, 0);
        chk("idle_oe",       bus.ext_data_oe, 0);
        chk("idle_disp_q",   bus.ext_dispatcher_q, 1);

        // Enumeration strobe outside ENUM is ignored
        poll(1'b0, 8'h00, 32'h0);
        bus.ext_rst_i  = 1'b1;
        bus.ext_data_i = 32'h0000_0009;
        tick();
        chk("late_enum_idx", cpu_index, 8'h04);
        chk("late_enum_e",   bus.ext_rst_e, 0);
        bus.ext_rst_i = 1'b0;

        // Poll with the wrong index
        poll(1'b1, 8'h03, 32'h1000);
        tick();
        chk("wrong_idx_ack",  bus.ext_next_cpu_e, 0);
        chk("wrong_idx_next", core_next_state, 0);

        // Matching index, but bus busy
        poll(1'b1, 8'h04, 32'h1000);
        bus.ext_bus_busy_i = 1'b1;
        tick();
        chk("busy_idle_ack",  bus.ext_next_cpu_e, 0);
        chk("busy_idle_base", core_base_addr, 32'h0);

        // Matching poll in IDLE starts the core
        bus.ext_bus_busy_i = 1'b0;
        tick();
        chk("start_ack",    bus.ext_next_cpu_e, 1);
        chk("start_data",   bus.ext_data_o, 32'hA1);
        chk("start_oe",     bus.ext_data_oe, 1);
        chk("start_base",   core_base_addr, 32'h1000);
        chk("start_next",   core_next_state, 1);
        chk("start_disp_q", bus.ext_dispatcher_q, 0);
        chk("start_dn_0",   core_start_dn, 0);

        poll(1'b0, 8'h00, 32'h0);
        tick();
        chk("start_dn_1",  core_start_dn, 1);
        chk("next_pulse",  core_next_state, 0);

        // RUN, core not finished -> VOID
        core_state = 8'h01;
        poll(1'b1, 8'h04, 32'h0);
        tick();
        chk("void_ack",  bus.ext_next_cpu_e, 1);
        chk("void_data", bus.ext_data_o, 32'hA0);
        chk("start_dn_pulse", core_start_dn, 0);

        // Watchdog: 8 RUN cycles with no poll
        poll(1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        chk("wdog_7", timeout, 0);
        tick();
        chk("wdog_8", timeout, 1);
        tick();
        chk("wdog_sat", timeout, 1);

        // Read tagging in READ_DATA
        core_state  = 8'h11;
        core_read_q = 1'b1;
        tick();
        chk("tag_idx",    bus.ext_cpu_index_o, 8'h04);
        chk("tag_oe",     bus.ext_cpu_index_oe, 1);
        chk("tag_busy_o", bus.ext_bus_busy_o, 1);
        bus.ext_bus_busy_i = 1'b1;
        tick();
        chk("tag_busy_oe", bus.ext_cpu_index_oe, 0);
        bus.ext_bus_busy_i = 1'b0;
        core_read_q = 1'b0;
        tick();
        chk("tag_noreq_oe", bus.ext_cpu_index_oe, 0);

        // Matching poll clears the timeout
        poll(1'b1, 8'h04, 32'h0);
        tick();
        chk("wdog_clr",     timeout, 0);
        chk("wdog_clr_ack", bus.ext_next_cpu_e, 1);

        // Core finished, but bus busy -> no answer
        core_state = 8'h7F;
        bus.ext_bus_busy_i = 1'b1;
        tick();
        chk("end_busy_ack", bus.ext_next_cpu_e, 0);
        chk("end_busy_rst", core_rst, 0);

        // Core finished -> END, core reset pulse
        bus.ext_bus_busy_i = 1'b0;
        tick();
        chk("end_ack",      bus.ext_next_cpu_e, 1);
        chk("end_data",     bus.ext_data_o, 32'hA2);
        chk("end_core_rst", core_rst, 1);
        chk("end_disp_q",   bus.ext_dispatcher_q, 1);

        poll(1'b0, 8'h00, 32'h0);
        tick();
        chk("fin_core_rst", core_rst, 0);
        chk("fin_disp_q",   bus.ext_dispatcher_q, 1);
        chk("fin_ack",      bus.ext_next_cpu_e, 0);

        // Second job, then asynchronous reset in RUN
        core_state = 8'h01;
        poll(1'b1, 8'h04, 32'h2000);
        tick();
        chk("job2_base", core_base_addr, 32'h2000);
        poll(1'b0, 8'h00, 32'h0);
        tick();
        tick();
        #1;
        ext_rst_b = 1'b0;
        #1;
        chk("arst_core_rst", core_rst, 1);
        chk("arst_base",     core_base_addr, 32'h0);
        chk("arst_index",    cpu_index, 8'hFF);
        chk("arst_enum_err", enum_err, 0);
        chk("arst_disp_q",   bus.ext_dispatcher_q, 1);
        chk("arst_start_dn", core_start_dn, 0);
        tick();
        ext_rst_b = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ext_bridge_ctrl.md
Name: ext_bridge_ctrl

Overview:
- Parametrised successor bridge between one CPU core and the shared multi-CPU external bus.
- Acquires the core's CPU index through the reset enumeration daisy chain and answers dispatcher polls with CPU_R_* messages.
- Hands the dispatcher-supplied base address to the core and tags core reads with the CPU index.
- New relative to the previous generation: configurable widths, explicit output-enable ports instead of internal tristates, index-overflow detection, and a poll watchdog.

Parameters:
DATA_W, 32, external data bus width
ADDR_W, 32, address width
IDX_W, 8, CPU index width (IDX_W <= DATA_W)
STATE_W, 8, core state code width
WDOG_LIMIT, 1024, RUN cycles without a matching poll before timeout is flagged (>=1)

Ports:
clk  in  1  clock, rising edge
ext_rst_b  in  1  asynchronous active-low reset
ext_rst_i  in  1  upstream enumeration strobe; index valid on ext_data_i
ext_rst_e  out  1  downstream enumeration strobe (1-cycle pulse)
ext_data_i  in  DATA_W  external data in
ext_data_o  out  DATA_W  external data out
ext_data_oe  out  1  drive enable for ext_data_o
ext_addr_i  in  ADDR_W  dispatcher address (base address at start)
ext_bus_busy_i  in  1  bus owned by another agent
ext_bus_busy_o  out  1  this bridge claims the bus
ext_next_cpu_q  in  1  dispatcher poll strobe
ext_next_cpu_e  out  1  poll acknowledge
ext_cpu_index_i  in  IDX_W  polled CPU index
ext_cpu_index_o  out  IDX_W  own index tag for core reads
ext_cpu_index_oe  out  1  drive enable for ext_cpu_index_o
ext_dispatcher_q  out  1  request work from dispatcher
core_state  in  STATE_W  core FSM state
core_read_q  in  1  core read request
core_rst  out  1  core held in reset
core_next_state  out  1  1-cycle start pulse to core
core_base_addr  out  ADDR_W  latched program base address
core_start_dn  out  1  base address valid (1-cycle)
cpu_index  out  IDX_W  acquired index
enum_err  out  1  index overflow, sticky until reset
timeout  out  1  watchdog expired, cleared by next matching poll

Behaviour:
- Reset (async, ext_rst_b=0): state ENUM; core_rst=1; ext_dispatcher_q=1; cpu_index=all-ones. All other outputs and enables 0; core_base_addr=0; counters 0.
- Registered outputs throughout; response one cycle after the sampled input.
- ENUM
  - Waits for ext_rst_i.
  - On ext_rst_i: latch cpu_index=ext_data_i[IDX_W-1:0] and go to PASS.
  - If the latched value is all-ones, set enum_err=1 instead and stay in ENUM.
- PASS (1 cycle): ext_data_o=cpu_index+1, zero-extended; ext_data_oe=1; ext_bus_busy_o=1; ext_rst_e=1; core_rst=0; go to IDLE.
- Bus arbitration: while ext_bus_busy_i=1, no poll is answered and no outputs are driven in any state. The watchdog still counts.
- A poll matches when ext_next_cpu_q=1, ext_cpu_index_i==cpu_index and ext_bus_busy_i=0. Non-matching polls are ignored.
- Every matching poll drives ext_next_cpu_e=1 and ext_data_oe=1 for one cycle.
- IDLE: ext_dispatcher_q=1. On a matching poll: ext_data_o=CPU_R_START; latch core_base_addr=ext_addr_i; ext_dispatcher_q=0; core_next_state=1 (1 cycle); go to START.
- START (1 cycle): core_start_dn=1; go to RUN.
- RUN
  - On a matching poll: if core_state==FINISH_END, reply CPU_R_END and go to FINISH. Otherwise reply CPU_R_VOID.
  - While core_read_q=1 and core_state is one of READ_COND, READ_DATA or START_READ_CMD: ext_cpu_index_o=cpu_index and ext_cpu_index_oe=1, same cycle as registered.
- FINISH (1 cycle): core_rst=1; ext_dispatcher_q=1; go to IDLE. core_rst returns to 0 in IDLE.
- Watchdog
  - Counter of $clog2(WDOG_LIMIT+1) bits, active only in RUN, saturates at WDOG_LIMIT.
  - timeout=1 when the count reaches WDOG_LIMIT.
  - A matching poll clears both the counter and timeout. Leaving RUN clears the counter only.
- Simultaneous events: ext_rst_i in any state other than ENUM is ignored. A matching poll in ENUM or PASS is ignored (no ack).
- Reset mid-operation returns to ENUM asynchronously; core_base_addr is cleared.

Decomposition:
- Shared package cpu_bridge_pkg holds:
  - CPU_R_START, CPU_R_END, CPU_R_VOID message codes (DATA_W-wide localparams)
  - core state codes START_BEGIN, READ_COND, READ_DATA, START_READ_CMD, FINISH_END
  - bridge FSM enum {ENUM, PASS, IDLE, START, RUN, FINISH}
- One sub-module: bridge_poll_wdog (saturating counter, clear, timeout flag).

Test Plan:
- Release reset, ext_rst_i with ext_data_i=0x4 -> cpu_index=4; next cycle ext_rst_e=1, ext_data_o=0x5, ext_data_oe=1, ext_bus_busy_o=1; core_rst falls.
- ext_rst_i with ext_data_i=0xFF (IDX_W=8) -> enum_err=1, no ext_rst_e, core_rst stays 1.
- IDLE, poll index 4 with ext_addr_i=0x1000 -> ack, ext_data_o=CPU_R_START, core_base_addr=0x1000, core_next_state pulse, core_start_dn one cycle later; poll index 3 -> no response.
- RUN, poll with core_state≠FINISH_END -> CPU_R_VOID; then core_state=FINISH_END and poll -> CPU_R_END, core_rst pulse, ext_dispatcher_q=1; same poll with ext_bus_busy_i=1 -> no ack.
- WDOG_LIMIT=8, RUN without polls -> timeout=1 after 8 cycles; matching poll -> timeout=0; core_read_q=1 in READ_DATA -> ext_cpu_index_o=4, oe=1.
- Deassert ext_rst_b in RUN -> outputs at reset values immediately, state ENUM.
